// File: rtl/best_arr_sender_pkg.sv
// Shared types and default geometry for the best-array sender.
// The optional stall counter is enabled with BEST_ARR_SENDER_STALL_CNT_EN.
package best_arr_sender_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_ROW_SIZE = 26;
    localparam int DEF_COL_SIZE = 19;
    localparam int DEF_BLOCKING = 4;

    // Number of column blocks covering one half-row.
    function automatic int calc_nb(input int row_size, input int blocking);
        return ((row_size / 2) + blocking - 1) / blocking;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sender_skid_buf2.sv
// Two-entry FIFO that absorbs the one-cycle read latency of the best array.
// Push while full and pop while empty are ignored.
module sender_skid_buf2 #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push;
    logic       do_pop;

    assign do_push = push && (count_q != 2'd2);
    assign do_pop  = pop && (count_q != 2'd0);

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [WIDTH-1:0] ent_q, ent_d;

        always_comb begin
            ent_d = ent_q;
            if (do_push && (wr_ptr_q == 1'(gi))) begin
                ent_d = push_data;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ent_q <= '0;
            end else begin
                ent_q <= ent_d;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = rd_ptr_q ? g_entry[1].ent_q : g_entry[0].ent_q;
    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign count    = count_q;

endmodule

// File: rtl/best_arr_sender.sv
// Streams the best-match array into the output FIFO in px/x/y/xi block order.
// Define BEST_ARR_SENDER_STALL_CNT_EN to add the stall_cycles output.
module best_arr_sender
    import best_arr_sender_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int IDX_WIDTH  = 9,
    parameter int ROW_SIZE   = DEF_ROW_SIZE,
    parameter int COL_SIZE   = DEF_COL_SIZE,
    parameter int BLOCKING   = DEF_BLOCKING,
    parameter int ADDR_WIDTH = $clog2(ROW_SIZE * COL_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  send_best_arr,
    output logic                  send_done,
    output logic                  busy,
    output logic                  best_rd_en,
    output logic [ADDR_WIDTH-1:0] best_rd_addr,
    input  logic [IDX_WIDTH-1:0]  best_rd_data,
    output logic                  out_fifo_wenq,
    output logic [DATA_WIDTH-1:0] out_fifo_wdata,
`ifdef BEST_ARR_SENDER_STALL_CNT_EN
    output logic [15:0]           stall_cycles,
`endif
    input  logic                  out_fifo_wfull_n
);

    localparam int HALF = ROW_SIZE / 2;
    localparam int NB   = calc_nb(ROW_SIZE, BLOCKING);
    localparam int XW   = cnt_width(NB);
    localparam int YW   = cnt_width(COL_SIZE);
    localparam int XIW  = cnt_width(BLOCKING);

    state_t state_q, state_d;

    logic           px_q, px_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [XIW-1:0] xi_q, xi_d;
    logic           inflight_q;

    logic [31:0] col_idx;
    logic [31:0] addr_full;
    logic        last_xi, last_y, last_x, last_read;
    logic        start;
    logic        rd_en;
    logic        can_issue;

    logic                 buf_push, buf_pop, buf_full, buf_empty;
    logic [1:0]           buf_count;
    logic [1:0]           occ_after;
    logic [IDX_WIDTH-1:0] buf_head;
    logic [IDX_WIDTH-1:0] head_data;
    logic                 head_valid;
    logic                 wenq;

    // Address generation; trailing xi values past the half-row are folded
    // into the wrap condition so skipped tuples never cost a cycle.
    always_comb begin
        col_idx   = 32'(x_q) * 32'(BLOCKING) + 32'(xi_q);
        last_xi   = (32'(xi_q) == 32'(BLOCKING - 1)) || (col_idx + 32'd1 >= 32'(HALF));
        last_y    = (32'(y_q) == 32'(COL_SIZE - 1));
        last_x    = (32'(x_q) == 32'(NB - 1));
        last_read = px_q && last_x && last_y && last_xi;
        addr_full = 32'(px_q) * 32'(HALF) + 32'(y_q) * 32'(ROW_SIZE) + col_idx;
    end

    assign start     = (state_q == ST_IDLE) && send_best_arr;
    assign can_issue = !buf_full && ((buf_count == 2'd0) || !inflight_q);
    assign rd_en     = (state_q == ST_RUN) && can_issue;

    always_comb begin
        px_d = px_q;
        x_d  = x_q;
        y_d  = y_q;
        xi_d = xi_q;
        if (start) begin
            px_d = 1'b0;
            x_d  = '0;
            y_d  = '0;
            xi_d = '0;
        end else if (rd_en) begin
            if (!last_xi) begin
                xi_d = xi_q + XIW'(1);
            end else begin
                xi_d = '0;
                if (!last_y) begin
                    y_d = y_q + YW'(1);
                end else begin
                    y_d = '0;
                    if (!last_x) begin
                        x_d = x_q + XW'(1);
                    end else begin
                        x_d  = '0;
                        px_d = ~px_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            xi_q       <= '0;
            inflight_q <= 1'b0;
        end else begin
            px_q       <= px_d;
            x_q        <= x_d;
            y_q        <= y_d;
            xi_q       <= xi_d;
            inflight_q <= rd_en;
        end
    end

    // Returned data bypasses the empty buffer so a word can be enqueued in
    // the same cycle it arrives; otherwise it queues behind older words.
    assign head_valid = !buf_empty || inflight_q;
    assign wenq       = head_valid && out_fifo_wfull_n;
    assign buf_pop    = wenq && !buf_empty;
    assign buf_push   = inflight_q && !(buf_empty && wenq);
    assign head_data  = buf_empty ? best_rd_data : buf_head;
    assign occ_after  = buf_count + {1'b0, buf_push} - {1'b0, buf_pop};

    sender_skid_buf2 #(
        .WIDTH(IDX_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (buf_push),
        .push_data(best_rd_data),
        .pop      (buf_pop),
        .pop_data (buf_head),
        .full     (buf_full),
        .empty    (buf_empty),
        .count    (buf_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DRAIN looks at post-cycle occupancy so send_done lands one cycle
    // after the final enqueue.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (send_best_arr) state_d = ST_RUN;
            ST_RUN:   if (rd_en && last_read) state_d = ST_DRAIN;
            ST_DRAIN: if (occ_after == 2'd0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy           = (state_q != ST_IDLE);
        send_done      = (state_q == ST_DONE);
        best_rd_en     = rd_en;
        best_rd_addr   = rd_en ? ADDR_WIDTH'(addr_full) : '0;
        out_fifo_wenq  = wenq;
        out_fifo_wdata = head_valid ? DATA_WIDTH'(head_data) : '0;
    end

`ifdef BEST_ARR_SENDER_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start) begin
            stall_d = '0;
        end else if (head_valid && !out_fifo_wfull_n && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_best_arr_sender.sv
// Directed bench for best_arr_sender: ordering, back-pressure, restart and reset.
// Build with BEST_ARR_SENDER_STALL_CNT_EN to also check stall_cycles.
module tb_best_arr_sender;

    localparam int TOTAL = 494;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        send = 1'b0;
    logic        wfull_n = 1'b1;
    logic        send_done, busy, rd_en, wenq;
    logic [8:0]  rd_addr;
    logic [8:0]  rd_data = '0;
    logic [10:0] wdata;
`ifdef BEST_ARR_SENDER_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int n_asserts = 0;
    int n_fail = 0;

`define CHECK(tag, obs, exp) begin n_asserts++; assert ((obs) === (exp)) else begin n_fail++; $error("FAIL %s: observed=%0d expected=%0d", tag, (obs), (exp)); end end

    best_arr_sender dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .send_best_arr   (send),
        .send_done       (send_done),
        .busy            (busy),
        .best_rd_en      (rd_en),
        .best_rd_addr    (rd_addr),
        .best_rd_data    (rd_data),
        .out_fifo_wenq   (wenq),
        .out_fifo_wdata  (wdata),
`ifdef BEST_ARR_SENDER_STALL_CNT_EN
        .stall_cycles    (stall_cycles),
`endif
        .out_fifo_wfull_n(wfull_n)
    );

    always #5 clk = ~clk;

    // Monitor: samples settled values mid-cycle, models mem[a] = a.
    int   cyc = 0;
    int   words[$];
    int   raddrs[$];
    int   exp_q[$];
    int   first_rd_cyc, first_wr_cyc, last_wr_cyc, done_cyc;
    bit   done_seen;
    int   outstanding, max_out, bad_wenq;
    logic       pend_en = 1'b0;
    logic [8:0] pend_addr = '0;

    always @(negedge clk) begin
        cyc++;
        pend_en   = rd_en;
        pend_addr = rd_addr;
        if (rst_n) begin
            if (rd_en) begin
                if (raddrs.size() == 0) first_rd_cyc = cyc;
                raddrs.push_back(int'(rd_addr));
                outstanding++;
            end
            if (wenq) begin
                if (words.size() == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                words.push_back(int'(wdata));
                outstanding--;
                if (!wfull_n) bad_wenq++;
            end
            if (outstanding > max_out) max_out = outstanding;
            if (send_done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
    end

    always @(posedge clk) rd_data <= pend_en ? pend_addr : 9'h1A5;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        words.delete();
        raddrs.delete();
        done_seen   = 1'b0;
        outstanding = 0;
        max_out     = 0;
        bad_wenq    = 0;
    endtask

    task automatic start_xfer();
        clear_mon();
        send = 1'b1;
        step();
        send = 1'b0;
    endtask

    task automatic run_until_words(input int n);
        for (int i = 0; i < 2000 && words.size() < n; i++) step();
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && !done_seen; i++) step();
        `CHECK(tag, done_seen, 1'b1)
    endtask

    function automatic int seq_errors();
        int e = 0;
        if (words.size() != exp_q.size()) e++;
        for (int i = 0; i < words.size() && i < exp_q.size(); i++)
            if (words[i] != exp_q[i]) e++;
        return e;
    endfunction

    initial begin
        bit pulsed;
        int first_a [8] = '{0, 1, 2, 3, 26, 27, 28, 29};

        // Expected word order: px, x, y, xi nested; columns past 13 skipped.
        for (int px = 0; px < 2; px++)
            for (int x = 0; x < 4; x++)
                for (int y = 0; y < 19; y++)
                    for (int xi = 0; xi < 4; xi++)
                        if (x * 4 + xi < 13) exp_q.push_back(px * 13 + y * 26 + x * 4 + xi);

        // Reset state
        repeat (3) step();
        `CHECK("rst_busy", busy, 1'b0)
        `CHECK("rst_send_done", send_done, 1'b0)
        `CHECK("rst_rd_en", rd_en, 1'b0)
        `CHECK("rst_rd_addr", rd_addr, 9'd0)
        `CHECK("rst_wenq", wenq, 1'b0)
        `CHECK("rst_wdata", wdata, 11'd0)
        rst_n = 1'b1;
        step();

        // Free-flowing transfer, with a second start pulse at word 50
        start_xfer();
        pulsed = 1'b0;
        for (int i = 0; i < 3000 && !done_seen; i++) begin
            if (!pulsed && words.size() >= 50) begin
                send   = 1'b1;
                pulsed = 1'b1;
            end else begin
                send = 1'b0;
            end
            step();
        end
        send = 1'b0;
        `CHECK("a_done_seen", done_seen, 1'b1)
        for (int i = 0; i < 8; i++) `CHECK("a_first_addr", raddrs[i], first_a[i])
        `CHECK("a_word_count", words.size(), TOTAL)
        `CHECK("a_seq_errors", seq_errors(), 0)
        `CHECK("a_word228_x3", words[228], 12)
        `CHECK("a_word229_x3", words[229], 38)
        `CHECK("a_word247_px1", words[247], 13)
        `CHECK("a_first_latency", first_wr_cyc - first_rd_cyc, 1)
        `CHECK("a_throughput_span", last_wr_cyc - first_wr_cyc, TOTAL - 1)
        `CHECK("a_done_after_last", done_cyc - last_wr_cyc, 1)
        `CHECK("a_busy_after_done", busy, 1'b0)
        step();

        // 20-cycle back-pressure after word 100
        start_xfer();
        run_until_words(100);
        wfull_n = 1'b0;
        repeat (20) step();
        wfull_n = 1'b1;
        wait_done("b_done_seen");
        `CHECK("b_max_outstanding", max_out, 2)
        `CHECK("b_wenq_while_full", bad_wenq, 0)
        `CHECK("b_word_count", words.size(), TOTAL)
        `CHECK("b_seq_errors", seq_errors(), 0)
        `CHECK("b_span_with_stall", last_wr_cyc - first_wr_cyc, TOTAL - 1 + 20)
`ifdef BEST_ARR_SENDER_STALL_CNT_EN
        `CHECK("b_stall_cycles", stall_cycles, 16'd20)
`endif
        step();

        // Random back-pressure
        start_xfer();
        for (int i = 0; i < 5000 && !done_seen; i++) begin
            wfull_n = 1'($urandom_range(0, 1));
            step();
        end
        wfull_n = 1'b1;
        `CHECK("c_done_seen", done_seen, 1'b1)
        `CHECK("c_outstanding_le2", (max_out <= 2), 1'b1)
        `CHECK("c_wenq_while_full", bad_wenq, 0)
        `CHECK("c_word_count", words.size(), TOTAL)
        `CHECK("c_seq_errors", seq_errors(), 0)
        step();

        // Reset mid-transfer, then restart from scratch
        start_xfer();
        run_until_words(100);
        rst_n = 1'b0;
        #1;
        `CHECK("d_rst_busy", busy, 1'b0)
        `CHECK("d_rst_send_done", send_done, 1'b0)
        `CHECK("d_rst_rd_en", rd_en, 1'b0)
        `CHECK("d_rst_rd_addr", rd_addr, 9'd0)
        `CHECK("d_rst_wenq", wenq, 1'b0)
        `CHECK("d_rst_wdata", wdata, 11'd0)
`ifdef BEST_ARR_SENDER_STALL_CNT_EN
        `CHECK("d_rst_stall", stall_cycles, 16'd0)
`endif
        repeat (2) step();
        rst_n = 1'b1;
        step();
        start_xfer();
        wait_done("d_done_seen");
        `CHECK("d_first_addr", raddrs[0], 0)
        `CHECK("d_word_count", words.size(), TOTAL)
        `CHECK("d_seq_errors", seq_errors(), 0)

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
